stream2sync: RTL and testbench



---
 rtl/stream2sync.sv | 185 ++++++++++++++++++
 tb/tb_stream2sync.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream2sync.sv
// stream2sync: turns an AXI-stream video feed back into sync-based raw video.
//
// A free-running raster built from a latched mode line generates pixel
// valid, hsync and vsync. Stream beats are pulled only during active pixels
// while locked (state RUN). Marker checks detect loss of alignment. The block
// then falls back to SYNC, finds the frame boundary, waits in WAIT for the
// raster origin, and locks again.
//
// Parameters:
//   OPT_INVERT_HSYNC  1: o_hsync active-low
//   OPT_INVERT_VSYNC  1: o_vsync active-low
//   OPT_TUSER_IS_SOF  0: TLAST = end of frame, TUSER = end of line
//                     1: TUSER = start of frame, TLAST = end of line
// Optional build macro:
//   STREAM2SYNC_UNDERFLOW_COUNT_EN  build the saturating underflow counter
//                                   (otherwise o_underflows is constant 0)
//
// Ports:
//   i_clk, i_reset        pixel clock, synchronous active-high reset
//   S_AXIS_*              24-bit RGB video stream input
//   i_width .. i_raw_width    active pixels, hsync start, hsync end, clocks/line
//   i_height .. i_raw_height  active lines, vsync start, vsync end, lines/frame
//   o_pix_valid, o_hsync, o_vsync, o_pixel  registered raw video
//   o_locked              stream aligned with the raster
//   o_underflows          count of active pixels missed while locked
module stream2sync #(
  parameter bit OPT_INVERT_HSYNC = 1'b0,
  parameter bit OPT_INVERT_VSYNC = 1'b0,
  parameter bit OPT_TUSER_IS_SOF = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [23:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TUSER,
  input  logic [15:0] i_width,
  input  logic [15:0] i_hfront,
  input  logic [15:0] i_hsync,
  input  logic [15:0] i_raw_width,
  input  logic [15:0] i_height,
  input  logic [15:0] i_vfront,
  input  logic [15:0] i_vsync,
  input  logic [15:0] i_raw_height,
  output logic        o_pix_valid,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [23:0] o_pixel,
  output logic        o_locked,
  output logic [15:0] o_underflows
);

  typedef enum logic [1:0] {StSync, StWait, StRun} state_e;

  state_e      state_q, state_d;
  logic [15:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [15:0] width_q, hfront_q, hsync_q, raw_width_q;
  logic [15:0] height_q, vfront_q, vsync_q, raw_height_q;

  logic hlast, vlast, wrap, active, at_origin, last_px, last_ln;
  logic hsync_act, vsync_act;
  logic le, marker_err, sof_bad, accept;
  logic [23:0] pixel_d;

  // Raster position; 16'hffff also wraps so a bad mode cannot run away.
  always_comb begin
    hlast     = (hpos_q == raw_width_q - 16'd1) || (hpos_q == 16'hffff);
    vlast     = (vpos_q == raw_height_q - 16'd1) || (vpos_q == 16'hffff);
    wrap      = hlast && vlast;
    hpos_d    = hlast ? 16'd0 : hpos_q + 16'd1;
    vpos_d    = vpos_q;
    if (hlast) vpos_d = vlast ? 16'd0 : vpos_q + 16'd1;
    active    = (hpos_q < width_q) && (vpos_q < height_q);
    at_origin = (hpos_q == 16'd0) && (vpos_q == 16'd0);
    last_px   = (hpos_q == width_q - 16'd1);
    last_ln   = (vpos_q == height_q - 16'd1);
    hsync_act = (hpos_q >= hfront_q) && (hpos_q < hsync_q);
    vsync_act = (vpos_q >= vfront_q) && (vpos_q < vsync_q);
  end

  // Marker decode and alignment checks for the beat on the bus.
  always_comb begin
    le         = OPT_TUSER_IS_SOF ? S_AXIS_TLAST : S_AXIS_TUSER;
    marker_err = (le != last_px);
    if (OPT_TUSER_IS_SOF) marker_err = marker_err | (S_AXIS_TUSER != at_origin);
    else                  marker_err = marker_err | (S_AXIS_TLAST != (last_px && last_ln));
    // A start-of-frame beat in the wrong place is held back for SYNC to use.
    sof_bad    = OPT_TUSER_IS_SOF && S_AXIS_TVALID && S_AXIS_TUSER && !at_origin;
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= StSync;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StSync: begin
        if (OPT_TUSER_IS_SOF) begin
          if (S_AXIS_TVALID && S_AXIS_TUSER) state_d = StWait;
        end else if (accept && S_AXIS_TLAST) begin
          state_d = StWait;
        end
      end
      StWait:  if (wrap) state_d = StRun;
      StRun:   if ((accept && marker_err) || (active && sof_bad)) state_d = StSync;
      default: state_d = StSync;
    endcase
  end

  // FSM outputs
  always_comb begin
    S_AXIS_TREADY = 1'b0;
    case (state_q)
      StSync:  S_AXIS_TREADY = OPT_TUSER_IS_SOF ? !(S_AXIS_TVALID && S_AXIS_TUSER) : 1'b1;
      StWait:  S_AXIS_TREADY = 1'b0;
      StRun:   S_AXIS_TREADY = active && !sof_bad;
      default: S_AXIS_TREADY = 1'b0;
    endcase
    if (i_reset) S_AXIS_TREADY = 1'b0;
    accept   = S_AXIS_TVALID && S_AXIS_TREADY;
    pixel_d  = (state_q == StRun && active && accept) ? S_AXIS_TDATA : 24'd0;
    o_locked = (state_q == StRun);
  end

  // Raster, mode latch and registered video outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hpos_q       <= 16'd0;
      vpos_q       <= 16'd0;
      width_q      <= i_width;
      hfront_q     <= i_hfront;
      hsync_q      <= i_hsync;
      raw_width_q  <= i_raw_width;
      height_q     <= i_height;
      vfront_q     <= i_vfront;
      vsync_q      <= i_vsync;
      raw_height_q <= i_raw_height;
      o_pix_valid  <= 1'b0;
      o_hsync      <= OPT_INVERT_HSYNC;
      o_vsync      <= OPT_INVERT_VSYNC;
      o_pixel      <= 24'd0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      // New mode takes effect only from the next frame origin.
      if (wrap) begin
        width_q      <= i_width;
        hfront_q     <= i_hfront;
        hsync_q      <= i_hsync;
        raw_width_q  <= i_raw_width;
        height_q     <= i_height;
        vfront_q     <= i_vfront;
        vsync_q      <= i_vsync;
        raw_height_q <= i_raw_height;
      end
      o_pix_valid <= active;
      o_hsync     <= hsync_act ^ OPT_INVERT_HSYNC;
      o_vsync     <= vsync_act ^ OPT_INVERT_VSYNC;
      o_pixel     <= pixel_d;
    end
  end

`ifdef STREAM2SYNC_UNDERFLOW_COUNT_EN
  logic [15:0] underflows_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      underflows_q <= 16'd0;
    end else if (state_q == StRun && active && !S_AXIS_TVALID &&
                 underflows_q != 16'hffff) begin
      underflows_q <= underflows_q + 16'd1;
    end
  end

  assign o_underflows = underflows_q;
`else
  assign o_underflows = 16'd0;
`endif

endmodule

// File: tb/tb_stream2sync.sv
// Bench for stream2sync: dut0 uses default markers and normal sync polarity,
// dut1 uses start-of-frame markers with both syncs inverted. A phase table
// scripts the stream; every cycle the expected video outputs for the current
// raster slot are queued and compared one clock later.
module tb_stream2sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1;
  logic        tvalid, tlast, tuser;
  logic [23:0] tdata;
  logic [15:0] width = 16'd4, hfront = 16'd5, hsync = 16'd6, raw_width = 16'd8;
  logic [15:0] height = 16'd3, vfront = 16'd4, vsync = 16'd5, raw_height = 16'd6;

  logic        ready0, pv0, hs0, vs0, lk0;
  logic [23:0] pix0;
  logic [15:0] uf0;
  logic        ready1, pv1, hs1, vs1, lk1;
  logic [23:0] pix1;
  logic [15:0] uf1;

  stream2sync #(
    .OPT_INVERT_HSYNC(1'b0),
    .OPT_INVERT_VSYNC(1'b0),
    .OPT_TUSER_IS_SOF(1'b0)
  ) u_dut0 (
    .i_clk(clk), .i_reset(rst0),
    .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(ready0), .S_AXIS_TDATA(tdata),
    .S_AXIS_TLAST(tlast), .S_AXIS_TUSER(tuser),
    .i_width(width), .i_hfront(hfront), .i_hsync(hsync), .i_raw_width(raw_width),
    .i_height(height), .i_vfront(vfront), .i_vsync(vsync), .i_raw_height(raw_height),
    .o_pix_valid(pv0), .o_hsync(hs0), .o_vsync(vs0), .o_pixel(pix0),
    .o_locked(lk0), .o_underflows(uf0)
  );

  stream2sync #(
    .OPT_INVERT_HSYNC(1'b1),
    .OPT_INVERT_VSYNC(1'b1),
    .OPT_TUSER_IS_SOF(1'b1)
  ) u_dut1 (
    .i_clk(clk), .i_reset(rst1),
    .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(ready1), .S_AXIS_TDATA(tdata),
    .S_AXIS_TLAST(tlast), .S_AXIS_TUSER(tuser),
    .i_width(width), .i_hfront(hfront), .i_hsync(hsync), .i_raw_width(raw_width),
    .i_height(height), .i_vfront(vfront), .i_vsync(vsync), .i_raw_height(raw_height),
    .o_pix_valid(pv1), .o_hsync(hs1), .o_vsync(vs1), .o_pixel(pix1),
    .o_locked(lk1), .o_underflows(uf1)
  );

`ifdef STREAM2SYNC_UNDERFLOW_COUNT_EN
  localparam int UF2 = 2;
`else
  localparam int UF2 = 0;
`endif

  // One script step: which DUT, reset, stream on, restart beat (-1 keep),
  // glitch beats (-1 none), length, expected lock, underflow check (-1 none).
  typedef struct {
    bit sel; bit rst; bit on; int beat; int glast; int gsof; int ncyc; bit run; int uf;
  } phase_t;

  typedef struct {
    bit sel; logic pv; logic hs; logic vs; logic [23:0] pix;
  } exp_t;

  phase_t ph[$];
  exp_t   q[$];
  bit     hact_t[8], hsy_t[8], vact_t[6], vsy_t[6];

  int errors = 0, checks = 0;
  int k, b, glast, gsof, uf_req;
  bit acc_prev, cur_sel, cur_rst, cur_on, cur_run;

  function automatic phase_t mk(bit sel, bit rst, bit on, int beat, int gl, int gs,
                                int n, bit run, int uf);
    phase_t p;
    p.sel = sel; p.rst = rst; p.on = on; p.beat = beat; p.glast = gl; p.gsof = gs;
    p.ncyc = n; p.run = run; p.uf = uf;
    return p;
  endfunction

  function automatic exp_t outs(bit s);
    exp_t o;
    o.sel = s;
    o.pv  = s ? pv1 : pv0;
    o.hs  = s ? hs1 : hs0;
    o.vs  = s ? vs1 : vs0;
    o.pix = s ? pix1 : pix0;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d k=%0d: got %0h want %0h", name, cur_sel, k, act, req);
    end
  endtask

  task automatic step();
    exp_t e, o;
    int   h, v;
    logic rdy;
    bit   exp_acc;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      o = outs(e.sel);
      check("pix_valid", 32'(o.pv), 32'(e.pv));
      check("hsync", 32'(o.hs), 32'(e.hs));
      check("vsync", 32'(o.vs), 32'(e.vs));
      check("pixel", 32'(o.pix), 32'(e.pix));
    end
    check("locked", 32'(cur_sel ? lk1 : lk0), 32'(cur_run));
    if (uf_req >= 0) begin
      check("underflows", 32'(cur_sel ? uf1 : uf0), 32'(uf_req));
      uf_req = -1;
    end
    if (acc_prev) begin
      if (b == glast) glast = -1;
      if (b == gsof) gsof = -1;
      b = (b + 1) % 12;
    end
    rst0   = cur_sel ? 1'b1 : cur_rst;
    rst1   = cur_sel ? cur_rst : 1'b1;
    tvalid = cur_on;
    tdata  = {8'h5a, 8'(b / 4), 8'(b % 4)};
    if (!cur_sel) begin
      tlast = (b == 11) || (b == glast);
      tuser = (b % 4 == 3);
    end else begin
      tuser = (b == 0) || (b == gsof);
      tlast = (b % 4 == 3);
    end
    #1;
    rdy      = cur_sel ? ready1 : ready0;
    acc_prev = tvalid && rdy;
    h        = k % 8;
    v        = (k / 8) % 6;
    e.sel    = cur_sel;
    if (cur_rst) begin
      check("tready_in_reset", 32'(rdy), 32'd0);
      e.pv  = 1'b0;
      e.hs  = cur_sel;
      e.vs  = cur_sel;
      e.pix = 24'd0;
      k     = 0;
    end else begin
      e.pv    = hact_t[h] && vact_t[v];
      e.hs    = hsy_t[h] ^ cur_sel;
      e.vs    = vsy_t[v] ^ cur_sel;
      // A start-of-frame beat away from the origin is never consumed.
      exp_acc = !(cur_sel && tuser && !(h == 0 && v == 0));
      e.pix   = (cur_run && e.pv && tvalid && exp_acc) ? tdata : 24'd0;
      k++;
    end
    q.push_back(e);
  endtask

  initial begin
    hact_t = '{1, 1, 1, 1, 0, 0, 0, 0};
    hsy_t  = '{0, 0, 0, 0, 0, 1, 0, 0};
    vact_t = '{1, 1, 1, 0, 0, 0};
    vsy_t  = '{0, 0, 0, 0, 1, 0};

    // dut0: default markers
    ph.push_back(mk(0, 1, 0, -1, -1, -1,  2, 0, -1));  // reset
    ph.push_back(mk(0, 0, 1,  0, -1, -1, 48, 0,  0));  // SYNC eats frame, WAIT
    ph.push_back(mk(0, 0, 1, -1, -1, -1, 48, 1, -1));  // locked steady frame
    ph.push_back(mk(0, 0, 1, -1,  9, -1, 18, 1, -1));  // TLAST on beat 10
    ph.push_back(mk(0, 0, 1, -1, -1, -1, 30, 0, -1));  // resync
    ph.push_back(mk(0, 0, 1, -1, -1, -1, 49, 1, -1));  // relocked
    ph.push_back(mk(0, 0, 0, -1, -1, -1,  2, 1, -1));  // two missed slots
    ph.push_back(mk(0, 0, 1, -1, -1, -1,  1, 1, -1));  // late beat, LE mismatch
    ph.push_back(mk(0, 0, 1, -1, -1, -1, 44, 0, UF2));
    ph.push_back(mk(0, 0, 1, -1, -1, -1, 10, 1, -1));
    ph.push_back(mk(0, 1, 1, -1, -1, -1,  1, 1, -1));  // reset mid-line
    ph.push_back(mk(0, 1, 0, -1, -1, -1,  1, 0,  0));
    ph.push_back(mk(0, 0, 0, -1, -1, -1, 20, 0, -1));  // idle
    ph.push_back(mk(0, 0, 1,  6, -1, -1, 28, 0, -1));  // stream joins at beat 7
    ph.push_back(mk(0, 0, 1, -1, -1, -1,  8, 1, -1));
    ph.push_back(mk(0, 1, 1, -1, -1, -1,  1, 1, -1));
    ph.push_back(mk(0, 1, 0, -1, -1, -1,  1, 0, -1));
    // dut1: start-of-frame markers, inverted syncs
    ph.push_back(mk(1, 1, 0, -1, -1, -1,  2, 0, -1));
    ph.push_back(mk(1, 0, 1,  0, -1, -1, 48, 0,  0));  // SOF pending, WAIT
    ph.push_back(mk(1, 0, 1, -1, -1, -1, 48, 1, -1));
    ph.push_back(mk(1, 0, 1, -1, -1,  5, 10, 1, -1));  // TUSER on beat 6
    ph.push_back(mk(1, 0, 1, -1, -1, -1, 38, 0, -1));  // held beat waits
    ph.push_back(mk(1, 0, 1, -1, -1, -1,  3, 1, -1));  // held beat at origin
    ph.push_back(mk(1, 0, 1, -1, -1, -1, 45, 0, -1));  // LE mismatch, resync
    ph.push_back(mk(1, 0, 1, -1, -1, -1, 10, 1, -1));
    ph.push_back(mk(1, 1, 1, -1, -1, -1,  1, 1, -1));  // reset mid-line
    ph.push_back(mk(1, 1, 0, -1, -1, -1,  2, 0,  0));

    rst0 = 1'b1; rst1 = 1'b1;
    tvalid = 1'b0; tdata = 24'd0; tlast = 1'b0; tuser = 1'b0;
    k = 0; b = 0; glast = -1; gsof = -1; uf_req = -1; acc_prev = 1'b0;
    cur_sel = 1'b0; cur_rst = 1'b1; cur_on = 1'b0; cur_run = 1'b0;
    repeat (3) @(posedge clk);

    foreach (ph[i]) begin
      cur_sel = ph[i].sel;
      cur_rst = ph[i].rst;
      cur_on  = ph[i].on;
      cur_run = ph[i].run;
      uf_req  = ph[i].uf;
      if (ph[i].beat >= 0) begin
        b        = ph[i].beat;
        acc_prev = 1'b0;
      end
      if (ph[i].glast >= 0) glast = ph[i].glast;
      if (ph[i].gsof >= 0) gsof = ph[i].gsof;
      for (int c = 0; c < ph[i].ncyc; c++) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
